// File: rtl/ras_pkg.sv
// Shared types and defaults for the return-address-stack controller.
//   RAS_DEPTH / RAS_ADDR / RAS_WIDTH : default stack geometry
//   ras_ckpt_t : checkpoint payload (pointer, occupancy, TOS value)
//   ras_op_e   : per-cycle operation after priority decode
package ras_pkg;

  localparam int unsigned RAS_DEPTH = 1024;
  localparam int unsigned RAS_ADDR  = 10;
  localparam int unsigned RAS_WIDTH = 36;

  typedef struct packed {
    logic [RAS_ADDR-1:0]  ptr;
    logic [RAS_ADDR:0]    cnt;
    logic [RAS_WIDTH-1:0] top;
  } ras_ckpt_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUSH    = 3'd1,
    POP     = 3'd2,
    REPL    = 3'd3,
    RESTORE = 3'd4
  } ras_op_e;

endpackage

// File: rtl/ras_ctrl.sv
// Return-address-stack controller driving an external dual-port BRAM
// (port A write-only, port B read-only, 1-cycle read latency).
// TOS and the entry below it are held in registers so predictions are
// available with zero latency; the BRAM only backs the deeper entries.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   push_valid, push_addr    call: push return address
//   pop_valid                return: pop TOS
//   pred_valid, pred_addr    prediction (stack non-empty, TOS value)
//   ckpt_ptr, ckpt_cnt       checkpoint export (TOS pointer, occupancy)
//   restore_*                checkpoint restore (highest priority)
//   mem_wea/waddra/wia       BRAM port A (write)
//   mem_reb/raddrb, mem_dob  BRAM port B (read, data one cycle later)
//   ovf_cnt, unf_cnt         saturating overflow/underflow counters,
//                            present only when RAS_STATS_EN is defined
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH,
  parameter int unsigned ADDR  = RAS_ADDR,
  parameter int unsigned WIDTH = RAS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_addr,
  input  logic             pop_valid,
  output logic             pred_valid,
  output logic [WIDTH-1:0] pred_addr,
  output logic [ADDR-1:0]  ckpt_ptr,
  output logic [ADDR:0]    ckpt_cnt,
  input  logic             restore_valid,
  input  logic [ADDR-1:0]  restore_ptr,
  input  logic [ADDR:0]    restore_cnt,
  input  logic [WIDTH-1:0] restore_top,
  output logic             mem_wea,
  output logic [ADDR-1:0]  mem_waddra,
  output logic [WIDTH-1:0] mem_wia,
  output logic             mem_reb,
  output logic [ADDR-1:0]  mem_raddrb,
  input  logic [WIDTH-1:0] mem_dob
`ifdef RAS_STATS_EN
  ,
  output logic [15:0]      ovf_cnt,
  output logic [15:0]      unf_cnt
`endif
);

  localparam int unsigned CW = ADDR + 1;
  localparam logic [ADDR:0] FULL = CW'(DEPTH);

  logic [ADDR-1:0]  tos_ptr;
  logic [ADDR:0]    count;
  logic [WIDTH-1:0] top_q;
  logic [WIDTH-1:0] next_q;
  logic             next_pend;
  logic [WIDTH-1:0] nxt;
  logic             empty;
  ras_op_e          op;

  assign empty      = (count == '0);
  // Bypass the BRAM read that lands this cycle so back-to-back pops have no bubble
  assign nxt        = next_pend ? mem_dob : next_q;
  assign pred_valid = !empty;
  assign pred_addr  = top_q;
  assign ckpt_ptr   = tos_ptr;
  assign ckpt_cnt   = count;

  // Priority decode; push+pop on an empty stack degenerates to a push
  always_comb begin
    op = IDLE;
    if (restore_valid)                          op = RESTORE;
    else if (push_valid && pop_valid && !empty) op = REPL;
    else if (push_valid)                        op = PUSH;
    else if (pop_valid)                         op = POP;
  end

  // BRAM port drive
  always_comb begin
    mem_wea    = 1'b0;
    mem_waddra = '0;
    mem_wia    = '0;
    mem_reb    = 1'b0;
    mem_raddrb = '0;
    case (op)
      RESTORE: begin
        mem_reb    = 1'b1;
        mem_raddrb = restore_ptr - ADDR'(1);
      end
      REPL: begin
        mem_wea    = 1'b1;
        mem_waddra = tos_ptr;
        mem_wia    = push_addr;
      end
      PUSH: begin
        mem_wea    = 1'b1;
        mem_waddra = tos_ptr + ADDR'(1);
        mem_wia    = push_addr;
      end
      POP: begin
        // New TOS comes from nxt; fetch the entry that becomes next-below
        if (!empty) begin
          mem_reb    = 1'b1;
          mem_raddrb = tos_ptr - ADDR'(2);
        end
      end
      default: ;
    endcase
  end

  // Pointer, occupancy and TOS/next cache
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tos_ptr   <= '0;
      count     <= '0;
      top_q     <= '0;
      next_q    <= '0;
      next_pend <= 1'b0;
    end else begin
      case (op)
        RESTORE: begin
          tos_ptr   <= restore_ptr;
          count     <= restore_cnt;
          top_q     <= restore_top;
          next_pend <= 1'b1;
        end
        REPL: begin
          top_q <= push_addr;
        end
        PUSH: begin
          tos_ptr   <= tos_ptr + ADDR'(1);
          count     <= (count == FULL) ? count : count + CW'(1);
          top_q     <= push_addr;
          next_q    <= top_q;
          next_pend <= 1'b0;
        end
        POP: begin
          if (!empty) begin
            tos_ptr   <= tos_ptr - ADDR'(1);
            count     <= count - CW'(1);
            top_q     <= nxt;
            next_pend <= 1'b1;
          end
        end
        default: begin
          if (next_pend) begin
            next_q    <= mem_dob;
            next_pend <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef RAS_STATS_EN
  // Saturating overflow (push while full) and underflow (pop while empty) counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else begin
      if (op == PUSH && count == FULL && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
      if (op == POP && empty && unf_cnt != 16'hFFFF)          unf_cnt <= unf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: one default-depth instance and one 4-deep instance
// share stimulus; each has its own BRAM model and behavioural stack model.
// Expected post-edge state is queued at drive time and compared after the edge.
module tb_ras_ctrl;

  localparam int unsigned W = 36;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          push_valid, pop_valid, restore_valid;
  logic [W-1:0]  push_addr, restore_top;
  logic [9:0]    restore_ptr;
  logic [10:0]   restore_cnt;

  logic          pv0, wea0, reb0;
  logic [W-1:0]  pa0, wi0, dob0;
  logic [9:0]    cp0, wa0, ra0;
  logic [10:0]   cc0;

  logic          pv1, wea1, reb1;
  logic [W-1:0]  pa1, wi1, dob1;
  logic [1:0]    cp1, wa1, ra1;
  logic [2:0]    cc1;

`ifdef RAS_STATS_EN
  logic [15:0]   ovf0, unf0, ovf1, unf1;
`endif

  logic [W-1:0]  bram0 [1024];
  logic [W-1:0]  bram1 [4];

  always @(posedge clk) begin
    if (wea0) bram0[wa0] <= wi0;
    if (reb0) dob0 <= bram0[ra0];
    if (wea1) bram1[wa1] <= wi1;
    if (reb1) dob1 <= bram1[ra1];
  end

  ras_ctrl u_dut0 (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_addr(push_addr), .pop_valid(pop_valid),
    .pred_valid(pv0), .pred_addr(pa0), .ckpt_ptr(cp0), .ckpt_cnt(cc0),
    .restore_valid(restore_valid), .restore_ptr(restore_ptr),
    .restore_cnt(restore_cnt), .restore_top(restore_top),
    .mem_wea(wea0), .mem_waddra(wa0), .mem_wia(wi0),
    .mem_reb(reb0), .mem_raddrb(ra0), .mem_dob(dob0)
`ifdef RAS_STATS_EN
    , .ovf_cnt(ovf0), .unf_cnt(unf0)
`endif
  );

  ras_ctrl #(.DEPTH(4), .ADDR(2), .WIDTH(W)) u_dut1 (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_addr(push_addr), .pop_valid(pop_valid),
    .pred_valid(pv1), .pred_addr(pa1), .ckpt_ptr(cp1), .ckpt_cnt(cc1),
    .restore_valid(restore_valid), .restore_ptr(restore_ptr[1:0]),
    .restore_cnt(restore_cnt[2:0]), .restore_top(restore_top),
    .mem_wea(wea1), .mem_waddra(wa1), .mem_wia(wi1),
    .mem_reb(reb1), .mem_raddrb(ra1), .mem_dob(dob1)
`ifdef RAS_STATS_EN
    , .ovf_cnt(ovf1), .unf_cnt(unf1)
`endif
  );

  // Behavioural stack model, one per instance
  logic [W-1:0]  ms [2][1024];
  int unsigned   mptr [2];
  int unsigned   mcnt [2];
  int unsigned   movf [2];
  int unsigned   munf [2];
  int unsigned   mdep [2];

  typedef struct {
    int unsigned sig;
    int unsigned inst;
    logic [63:0] exp;
  } sb_t;
  sb_t sbq [$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic string sname(int unsigned sig);
    case (sig)
      0: return "pred_valid";
      1: return "pred_addr";
      2: return "ckpt_ptr";
      3: return "ckpt_cnt";
      4: return "ovf_cnt";
      5: return "unf_cnt";
      6: return "mem_wea";
      7: return "mem_waddra";
      8: return "mem_wia";
      9: return "mem_reb";
      default: return "mem_raddrb";
    endcase
  endfunction

  function automatic logic [63:0] obs(int unsigned sig, int unsigned inst);
    logic [63:0] r;
    r = '0;
    case (sig)
      0: r = (inst != 0) ? 64'(pv1)  : 64'(pv0);
      1: r = (inst != 0) ? 64'(pa1)  : 64'(pa0);
      2: r = (inst != 0) ? 64'(cp1)  : 64'(cp0);
      3: r = (inst != 0) ? 64'(cc1)  : 64'(cc0);
`ifdef RAS_STATS_EN
      4: r = (inst != 0) ? 64'(ovf1) : 64'(ovf0);
      5: r = (inst != 0) ? 64'(unf1) : 64'(unf0);
`endif
      6: r = (inst != 0) ? 64'(wea1) : 64'(wea0);
      7: r = (inst != 0) ? 64'(wa1)  : 64'(wa0);
      8: r = (inst != 0) ? 64'(wi1)  : 64'(wi0);
      9: r = (inst != 0) ? 64'(reb1) : 64'(reb0);
      10: r = (inst != 0) ? 64'(ra1) : 64'(ra0);
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_sig(input int unsigned sig, input int unsigned inst, input logic [63:0] exp);
    check_val($sformatf("%s_i%0d", sname(sig), inst), obs(sig, inst), exp);
  endtask

  // Queue the expected post-edge architectural state of both instances
  task automatic push_expect();
    for (int i = 0; i < 2; i++) begin
      sbq.push_back('{0, i, 64'(mcnt[i] != 0)});
      if (mcnt[i] != 0) sbq.push_back('{1, i, 64'(ms[i][mptr[i]])});
      sbq.push_back('{2, i, 64'(mptr[i])});
      sbq.push_back('{3, i, 64'(mcnt[i])});
`ifdef RAS_STATS_EN
      sbq.push_back('{4, i, 64'(movf[i])});
      sbq.push_back('{5, i, 64'(munf[i])});
`endif
    end
  endtask

  task automatic drain();
    sb_t e;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk_sig(e.sig, e.inst, e.exp);
    end
  endtask

  // Combinational BRAM port expectations from pre-edge model state
  task automatic comb_chk(input int unsigned i, input logic pu, input logic po, input logic rs,
                          input logic [W-1:0] v, input int unsigned rp);
    int unsigned m;
    logic e_wea, e_reb;
    int unsigned e_wa, e_ra;
    m = mdep[i] - 1;
    e_wea = 1'b0; e_reb = 1'b0; e_wa = 0; e_ra = 0;
    if (rs) begin
      e_reb = 1'b1; e_ra = (rp + mdep[i] - 1) & m;
    end else if (pu && po && mcnt[i] != 0) begin
      e_wea = 1'b1; e_wa = mptr[i];
    end else if (pu) begin
      e_wea = 1'b1; e_wa = (mptr[i] + 1) & m;
    end else if (po && mcnt[i] != 0) begin
      e_reb = 1'b1; e_ra = (mptr[i] + mdep[i] - 2) & m;
    end
    chk_sig(6, i, 64'(e_wea));
    chk_sig(9, i, 64'(e_reb));
    if (e_wea) begin
      chk_sig(7, i, 64'(e_wa));
      chk_sig(8, i, 64'(v));
    end
    if (e_reb) chk_sig(10, i, 64'(e_ra));
  endtask

  task automatic model_update(input int unsigned i, input logic pu, input logic po, input logic rs,
                              input logic [W-1:0] v, input int unsigned rp, input int unsigned rc,
                              input logic [W-1:0] rt);
    int unsigned m;
    m = mdep[i] - 1;
    if (rs) begin
      mptr[i] = rp & m;
      mcnt[i] = rc;
      ms[i][mptr[i]] = rt;
    end else if (pu && po && mcnt[i] != 0) begin
      ms[i][mptr[i]] = v;
    end else if (pu) begin
      mptr[i] = (mptr[i] + 1) & m;
      ms[i][mptr[i]] = v;
      if (mcnt[i] == mdep[i]) begin
        if (movf[i] < 65535) movf[i]++;
      end else begin
        mcnt[i]++;
      end
    end else if (po) begin
      if (mcnt[i] != 0) begin
        mptr[i] = (mptr[i] + mdep[i] - 1) & m;
        mcnt[i]--;
      end else if (munf[i] < 65535) begin
        munf[i]++;
      end
    end
  endtask

  task automatic step(input logic pu, input logic po, input logic rs, input logic [W-1:0] v,
                      input int unsigned rp, input int unsigned rc, input logic [W-1:0] rt);
    @(negedge clk);
    push_valid    = pu;
    pop_valid     = po;
    restore_valid = rs;
    push_addr     = v;
    restore_ptr   = 10'(rp);
    restore_cnt   = 11'(rc);
    restore_top   = rt;
    #1;
    for (int i = 0; i < 2; i++) begin
      comb_chk(i, pu, po, rs, v, rp);
      model_update(i, pu, po, rs, v, rp, rc, rt);
    end
    push_expect();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic do_push(input logic [W-1:0] v); step(1'b1, 1'b0, 1'b0, v, 0, 0, '0); endtask
  task automatic do_pop();                     step(1'b0, 1'b1, 1'b0, '0, 0, 0, '0); endtask
  task automatic do_idle();                    step(1'b0, 1'b0, 1'b0, '0, 0, 0, '0); endtask
  task automatic do_repl(input logic [W-1:0] v); step(1'b1, 1'b1, 1'b0, v, 0, 0, '0); endtask

  task automatic reset_chk();
    for (int i = 0; i < 2; i++) begin
      chk_sig(0, i, 64'd0);
      chk_sig(1, i, 64'd0);
      chk_sig(2, i, 64'd0);
      chk_sig(3, i, 64'd0);
      chk_sig(6, i, 64'd0);
      chk_sig(9, i, 64'd0);
`ifdef RAS_STATS_EN
      chk_sig(4, i, 64'd0);
      chk_sig(5, i, 64'd0);
`endif
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mptr[i] = 0; mcnt[i] = 0; movf[i] = 0; munf[i] = 0;
    end
  endtask

  localparam logic [W-1:0] A1 = 36'h1_0000_0A01;
  localparam logic [W-1:0] A2 = 36'h2_0000_0A02;
  localparam logic [W-1:0] A3 = 36'h3_0000_0A03;
  localparam logic [W-1:0] B  = 36'hB_BBBB_0B00;
  localparam logic [W-1:0] C1 = 36'hC_0000_0C01;
  localparam logic [W-1:0] C2 = 36'hC_0000_0C02;

  initial begin
    mdep[0] = 1024;
    mdep[1] = 4;
    model_reset();
    rst = 1'b1;
    push_valid = 1'b0; pop_valid = 1'b0; restore_valid = 1'b0;
    push_addr = '0; restore_top = '0; restore_ptr = '0; restore_cnt = '0;
    #2;
    reset_chk();
    @(negedge clk);
    rst = 1'b0;

    // Pushes then back-to-back pops, plus an ignored pop on empty
    do_push(A1); do_push(A2); do_push(A3);
    do_pop(); do_pop(); do_pop(); do_pop();
    do_idle();

    // Checkpoint, push past it, restore, immediate pop
    do_push(A1); do_push(A2);
    do_push(C1); do_push(C2);
    step(1'b0, 1'b0, 1'b1, '0, 2, 2, A2);
    do_pop();

    // Replace TOS, then restore that overrides a simultaneous push+pop
    do_push(A2);
    do_repl(B);
    step(1'b1, 1'b1, 1'b1, C1, 2, 2, A2);
    do_pop();

    // Asynchronous reset in the middle of a pop
    @(negedge clk);
    pop_valid = 1'b1; push_valid = 1'b0; restore_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    reset_chk();
    model_reset();
    @(negedge clk);
    pop_valid = 1'b0;
    rst = 1'b0;

    // Overflow on the 4-deep instance, pops past the end
    for (int k = 1; k <= 5; k++) do_push(36'h5_0000_0000 + 36'(k));
    for (int k = 0; k < 5; k++) do_pop();

    // Idle between pops exercises the captured next-below path
    do_push(A1); do_push(A2); do_push(A3);
    do_pop(); do_idle(); do_idle(); do_pop();
    do_repl(B); do_pop();
    do_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
